// File: rtl/ramp_scan_lock_seq.sv
// Lock-acquisition sequencer: scans the ramp window for N periods, finds the signal
// maximum, parks the ramp there and enables the PIDs, rescanning on lock loss.
module ramp_scan_lock_seq #(
  parameter int unsigned R = 14
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          n_periods,
  input  logic [31:0]         timeout,
  input  logic signed [R-1:0] scan_low,
  input  logic signed [R-1:0] scan_hig,
  input  logic signed [R-1:0] sig_in,
  input  logic signed [R-1:0] ramp_a,
  input  logic                trig_low,
  input  logic                out_of_lock,
  output logic                ramp_enable,
  output logic                ramp_reset,
  output logic signed [R-1:0] ramp_low_lim,
  output logic signed [R-1:0] ramp_hig_lim,
  output logic                pid_enable,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic signed [R-1:0] peak_val,
  output logic signed [R-1:0] peak_pos,
  output logic [7:0]          relock_cnt,
  output logic [2:0]          state
);

  localparam int unsigned CW = 8;
  localparam int unsigned WW = 32;
  localparam logic signed [R-1:0] PEAK_MIN = {1'b1, {(R-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_SYNC   = 3'd2,
    S_SCAN   = 3'd3,
    S_SEEK   = 3'd4,
    S_LOCKED = 3'd5,
    S_ERR    = 3'd6
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         wd_q, wd_d;
  logic signed [R-1:0]   peak_val_q, peak_val_d;
  logic signed [R-1:0]   peak_pos_q, peak_pos_d;
  logic signed [R-1:0]   low_q, low_d;
  logic signed [R-1:0]   hig_q, hig_d;
  logic [CW-1:0]         relock_q, relock_d;
  logic                  ramp_reset_q, ramp_reset_d;
  logic                  pid_q, pid_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  wd_expired;
  logic                  at_target;

  assign wd_expired = (timeout != WW'(0)) && (wd_q <= WW'(1));
  assign at_target  = (ramp_a == peak_pos_q);

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wd_d       = wd_q;
    peak_val_d = peak_val_q;
    peak_pos_d = peak_pos_q;
    low_d      = low_q;
    hig_d      = hig_q;
    relock_d   = relock_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = (n_periods == CW'(0)) ? S_ERR : S_ARM;
      end
      S_ARM: begin
        state_d = S_SYNC;
        wd_d    = timeout;
      end
      S_SYNC: begin
        if (wd_q != WW'(0)) wd_d = wd_q - WW'(1);
        if (trig_low)        state_d = S_SCAN;
        else if (wd_expired) state_d = S_ERR;
      end
      S_SCAN: begin
        if (sig_in > peak_val_q) begin
          peak_val_d = sig_in;
          peak_pos_d = ramp_a;
        end
        if (trig_low) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == n_periods) begin
            state_d = S_SEEK;
            wd_d    = timeout;
          end
        end
      end
      S_SEEK: begin
        if (wd_q != WW'(0)) wd_d = wd_q - WW'(1);
        if (at_target)       state_d = S_LOCKED;
        else if (wd_expired) state_d = S_ERR;
      end
      S_LOCKED: begin
        if (out_of_lock) begin
          state_d = S_ARM;
          if (relock_q != {CW{1'b1}}) relock_d = relock_q + CW'(1);
        end else if (start) begin
          state_d = S_ARM;
        end
      end
      S_ERR: begin
        if (start && (n_periods != CW'(0))) state_d = S_ARM;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition but preserves results and statistics
    if (abort) begin
      state_d    = S_IDLE;
      relock_d   = relock_q;
      peak_val_d = peak_val_q;
      peak_pos_d = peak_pos_q;
    end

    // Arming latches the window so the ramp resets onto the new limits
    if (state_d == S_ARM) begin
      low_d      = scan_low;
      hig_d      = scan_hig;
      cnt_d      = CW'(0);
      peak_val_d = PEAK_MIN;
    end

    ramp_reset_d = (state_d == S_ARM);
    pid_d        = (state_d == S_LOCKED);
    done_d       = (state_d == S_LOCKED) && (state_q != S_LOCKED);
    busy_d       = (state_d == S_ARM) || (state_d == S_SYNC) ||
                   (state_d == S_SCAN) || (state_d == S_SEEK);
    err_d        = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      peak_val_q   <= '0;
      peak_pos_q   <= '0;
      low_q        <= '0;
      hig_q        <= '0;
      relock_q     <= '0;
      ramp_reset_q <= 1'b0;
      pid_q        <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      peak_val_q   <= peak_val_d;
      peak_pos_q   <= peak_pos_d;
      low_q        <= low_d;
      hig_q        <= hig_d;
      relock_q     <= relock_d;
      ramp_reset_q <= ramp_reset_d;
      pid_q        <= pid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  // Gated in the match cycle so the ramp cannot step past the target
  assign ramp_enable = ((state_q == S_SYNC) || (state_q == S_SCAN) || (state_q == S_SEEK)) &&
                       !((state_q == S_SEEK) && at_target);

  assign ramp_reset   = ramp_reset_q;
  assign ramp_low_lim = low_q;
  assign ramp_hig_lim = hig_q;
  assign pid_enable   = pid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign peak_val     = peak_val_q;
  assign peak_pos     = peak_pos_q;
  assign relock_cnt   = relock_q;
  assign state        = state_q;

endmodule

// File: tb/tb_ramp_scan_lock_seq.sv
// Scoreboard bench: a behavioural triangle ramp drives the sequencer; lock/error events are checked against queued expectations.
module tb_ramp_scan_lock_seq;

  localparam int unsigned RW = 14;

  logic                 clk, rstn, start, abort, trig_low, out_of_lock;
  logic [7:0]           n_periods;
  logic [31:0]          timeout;
  logic signed [RW-1:0] scan_low, scan_hig, sig_in, ramp_a;
  logic                 ramp_enable, ramp_reset, pid_enable, busy, done, err;
  logic signed [RW-1:0] ramp_low_lim, ramp_hig_lim, peak_val, peak_pos;
  logic [7:0]           relock_cnt;
  logic [2:0]           state;

  ramp_scan_lock_seq #(.R(RW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .n_periods(n_periods), .timeout(timeout),
    .scan_low(scan_low), .scan_hig(scan_hig),
    .sig_in(sig_in), .ramp_a(ramp_a), .trig_low(trig_low), .out_of_lock(out_of_lock),
    .ramp_enable(ramp_enable), .ramp_reset(ramp_reset),
    .ramp_low_lim(ramp_low_lim), .ramp_hig_lim(ramp_hig_lim),
    .pid_enable(pid_enable), .busy(busy), .done(done), .err(err),
    .peak_val(peak_val), .peak_pos(peak_pos), .relock_cnt(relock_cnt), .state(state)
  );

  typedef struct {
    int kind;      // 0 = lock (done pulse), 1 = error entry
    int pval;
    int ppos;
    int relock;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   sig_mode = 0;
  bit   trig_kill = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Triangle ramp model: registers enable/reset at the edge, updates 1 time unit later
  int rv = 0;
  bit up = 1'b1;
  always @(posedge clk) begin
    bit en, rr;
    int lo, hi, sv;
    en = ramp_enable;
    rr = ramp_reset;
    lo = int'($signed(ramp_low_lim));
    hi = int'($signed(ramp_hig_lim));
    #1;
    if (rr) begin
      rv = lo;
      up = 1'b1;
    end else if (en) begin
      if (up) begin
        if (rv >= hi) begin up = 1'b0; rv = rv - 1; end
        else rv = rv + 1;
      end else begin
        if (rv <= lo) begin up = 1'b1; rv = rv + 1; end
        else rv = rv - 1;
      end
    end
    ramp_a   = RW'(rv);
    trig_low = en && !rr && (rv == lo) && !trig_kill;
    if (sig_mode == 0) sv = (rv >= 37) ? -(rv - 37) : -(37 - rv);
    else               sv = (rv == 10 || rv == 20) ? 50 : 0;
    sig_in = RW'(sv);
  end

  // Monitor: compares whenever the DUT reports a lock or an error
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("lock_kind", 0, e.kind);
          chk("lock_peak_val", int'($signed(peak_val)), e.pval);
          chk("lock_peak_pos", int'($signed(peak_pos)), e.ppos);
          chk("lock_relock_cnt", int'(relock_cnt), e.relock);
          chk("lock_state", int'(state), 5);
          chk("lock_pid_enable", int'(pid_enable), 1);
        end
      end
      if (err && !err_prev) begin
        if (exp_q.size() == 0) chk("unexpected_err", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("err_kind", 1, e.kind);
          chk("err_state", int'(state), 6);
          chk("err_ramp_enable", int'(ramp_enable), 0);
        end
      end
    end
    err_prev = err;
  end

  task automatic push_exp(input int kind, input int pval, input int ppos, input int relock);
    exp_t e;
    e.kind = kind; e.pval = pval; e.ppos = ppos; e.relock = relock;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_state(input string name, input int s, input int max_cyc);
    bit got = 1'b0;
    for (int c = 0; c < max_cyc && !got; c++) begin
      @(negedge clk);
      if (int'(state) == s) got = 1'b1;
    end
    if (!got) chk(name, int'(state), s);
  endtask

  initial begin
    int viol, cnt;
    bit got;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; out_of_lock = 1'b0;
    n_periods = 8'd2; timeout = 32'd0;
    scan_low = -14'sd100; scan_hig = 14'sd100;
    trig_low = 1'b0; sig_in = '0; ramp_a = '0;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_outputs", {ramp_reset, pid_enable, busy, done, err, ramp_enable}, 0);
    chk("rst_peak_val", int'($signed(peak_val)), 0);
    chk("rst_relock", int'(relock_cnt), 0);
    @(negedge clk) rstn = 1'b1;

    // Illegal count
    n_periods = 8'd0;
    push_exp(1, 0, 0, 0);
    pulse_start();
    chk("illegal_state", int'(state), 6);
    chk("illegal_err", int'(err), 1);
    chk("illegal_ramp_en", int'(ramp_enable), 0);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("err_abort_state", int'(state), 0);
    chk("err_abort_err", int'(err), 0);

    // Nominal scan
    n_periods = 8'd2;
    push_exp(0, 0, 37, 0);
    pulse_start();
    chk("arm_state", int'(state), 1);
    chk("arm_ramp_reset", int'(ramp_reset), 1);
    chk("arm_low_lim", int'($signed(ramp_low_lim)), -100);
    @(negedge clk);
    chk("sync_state", int'(state), 2);
    chk("sync_ramp_reset", int'(ramp_reset), 0);
    wait_state("nominal_lock_timeout", 5, 3000);
    repeat (5) @(negedge clk);
    chk("held_ramp", int'($signed(ramp_a)), 37);
    chk("held_pid", int'(pid_enable), 1);
    chk("held_done", int'(done), 0);

    // Relock three times
    for (int i = 1; i <= 3; i++) begin
      push_exp(0, 0, 37, i);
      @(negedge clk) out_of_lock = 1'b1;
      @(negedge clk) out_of_lock = 1'b0;
      chk("relock_arm_state", int'(state), 1);
      chk("relock_pid_low", int'(pid_enable), 0);
      chk("relock_cnt", int'(relock_cnt), i);
      viol = 0; got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge clk);
        if (busy && pid_enable) viol++;
        if (state == 3'd5) got = 1'b1;
      end
      chk("relock_reached_lock", int'(got), 1);
      chk("relock_pid_during_scan", viol, 0);
    end

    // Tie: first occurrence at ramp 10 wins over 20
    sig_mode = 1; n_periods = 8'd1;
    scan_low = -14'sd30; scan_hig = 14'sd30;
    push_exp(0, 50, 10, 3);
    pulse_start();
    wait_state("tie_lock_timeout", 5, 1000);
    repeat (3) @(negedge clk);
    chk("tie_held_ramp", int'($signed(ramp_a)), 10);

    // Watchdog in SYNC
    trig_kill = 1'b1; timeout = 32'd50;
    push_exp(1, 0, 0, 0);
    pulse_start();
    wait_state("wd_sync_timeout", 2, 10);
    cnt = 0;
    while (state == 3'd2 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("wd_cycles", cnt, 50);
    chk("wd_state", int'(state), 6);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    trig_kill = 1'b0; timeout = 32'd0; sig_mode = 0; n_periods = 8'd2;

    // Abort mid-scan, with start held simultaneously
    pulse_start();
    wait_state("abort_scan_timeout", 3, 1000);
    repeat (20) @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort_state", int'(state), 0);
    chk("abort_enables", {pid_enable, ramp_enable, ramp_reset, busy}, 0);
    @(negedge clk);
    chk("abort_start_state", int'(state), 0);
    abort = 1'b0; start = 1'b0;

    // Asynchronous reset between edges
    pulse_start();
    wait_state("rst_scan_timeout", 3, 1000);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_relock", int'(relock_cnt), 0);
    chk("arst_peak_pos", int'($signed(peak_pos)), 0);
    chk("arst_low_lim", int'($signed(ramp_low_lim)), 0);
    chk("arst_busy", int'(busy), 0);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("arst_no_ramp_reset", int'(ramp_reset), 0);
    chk("arst_idle", int'(state), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
